// File: rtl/top.sv
// rtl/top.sv - two-stage registered word datapath with address-decoded op/const configuration
module top (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [31:0] config_addr_in,
  input  logic [31:0] config_data_in,
  input  logic        pad_S0_T0_in,
  input  logic        pad_S0_T1_in,
  input  logic        pad_S0_T2_in,
  input  logic        pad_S0_T3_in,
  input  logic        pad_S0_T4_in,
  input  logic        pad_S0_T5_in,
  input  logic        pad_S0_T6_in,
  input  logic        pad_S0_T7_in,
  input  logic        pad_S0_T8_in,
  input  logic        pad_S0_T9_in,
  input  logic        pad_S0_T10_in,
  input  logic        pad_S0_T11_in,
  input  logic        pad_S0_T12_in,
  input  logic        pad_S0_T13_in,
  input  logic        pad_S0_T14_in,
  input  logic        pad_S0_T15_in,
  input  logic        pad_S1_T0_in,
  input  logic        pad_S1_T1_in,
  input  logic        pad_S1_T2_in,
  input  logic        pad_S1_T3_in,
  input  logic        pad_S1_T4_in,
  input  logic        pad_S1_T5_in,
  input  logic        pad_S1_T6_in,
  input  logic        pad_S1_T7_in,
  input  logic        pad_S1_T8_in,
  input  logic        pad_S1_T9_in,
  input  logic        pad_S1_T10_in,
  input  logic        pad_S1_T11_in,
  input  logic        pad_S1_T12_in,
  input  logic        pad_S1_T13_in,
  input  logic        pad_S1_T14_in,
  input  logic        pad_S1_T15_in,
  input  logic        pad_S2_T0_in,
  input  logic        pad_S2_T1_in,
  input  logic        pad_S2_T2_in,
  input  logic        pad_S2_T3_in,
  input  logic        pad_S2_T4_in,
  input  logic        pad_S2_T5_in,
  input  logic        pad_S2_T6_in,
  input  logic        pad_S2_T7_in,
  input  logic        pad_S2_T8_in,
  input  logic        pad_S2_T9_in,
  input  logic        pad_S2_T10_in,
  input  logic        pad_S2_T11_in,
  input  logic        pad_S2_T12_in,
  input  logic        pad_S2_T13_in,
  input  logic        pad_S2_T14_in,
  input  logic        pad_S2_T15_in,
  input  logic        pad_S3_T0_in,
  input  logic        pad_S3_T1_in,
  input  logic        pad_S3_T2_in,
  input  logic        pad_S3_T3_in,
  input  logic        pad_S3_T4_in,
  input  logic        pad_S3_T5_in,
  input  logic        pad_S3_T6_in,
  input  logic        pad_S3_T7_in,
  input  logic        pad_S3_T8_in,
  input  logic        pad_S3_T9_in,
  input  logic        pad_S3_T10_in,
  input  logic        pad_S3_T11_in,
  input  logic        pad_S3_T12_in,
  input  logic        pad_S3_T13_in,
  input  logic        pad_S3_T14_in,
  input  logic        pad_S3_T15_in,
  output logic        pad_S0_T0_out,
  output logic        pad_S0_T1_out,
  output logic        pad_S0_T2_out,
  output logic        pad_S0_T3_out,
  output logic        pad_S0_T4_out,
  output logic        pad_S0_T5_out,
  output logic        pad_S0_T6_out,
  output logic        pad_S0_T7_out,
  output logic        pad_S0_T8_out,
  output logic        pad_S0_T9_out,
  output logic        pad_S0_T10_out,
  output logic        pad_S0_T11_out,
  output logic        pad_S0_T12_out,
  output logic        pad_S0_T13_out,
  output logic        pad_S0_T14_out,
  output logic        pad_S0_T15_out,
  input  logic        tdi,
  input  logic        tms,
  input  logic        tck,
  input  logic        trst_n,
  output logic        tdo
);

  localparam logic [3:0] OP_DOUBLE = 4'd0;
  localparam logic [3:0] OP_PASS   = 4'd1;
  localparam logic [3:0] OP_ADDC   = 4'd2;
  localparam logic [3:0] OP_ADDB   = 4'd3;
  localparam logic [3:0] OP_AND    = 4'd4;

  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] ra;
  logic [15:0] rb;
  logic [15:0] rr;
  logic [15:0] result;
  logic [3:0]  op_reg;
  logic [15:0] const_reg;
  logic        cfg_hit;
  logic        unused_pins;

  // Pad T0 is the word MSB, T15 the LSB.
  assign a = {pad_S2_T0_in,  pad_S2_T1_in,  pad_S2_T2_in,  pad_S2_T3_in,
              pad_S2_T4_in,  pad_S2_T5_in,  pad_S2_T6_in,  pad_S2_T7_in,
              pad_S2_T8_in,  pad_S2_T9_in,  pad_S2_T10_in, pad_S2_T11_in,
              pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in};
  assign b = {pad_S3_T0_in,  pad_S3_T1_in,  pad_S3_T2_in,  pad_S3_T3_in,
              pad_S3_T4_in,  pad_S3_T5_in,  pad_S3_T6_in,  pad_S3_T7_in,
              pad_S3_T8_in,  pad_S3_T9_in,  pad_S3_T10_in, pad_S3_T11_in,
              pad_S3_T12_in, pad_S3_T13_in, pad_S3_T14_in, pad_S3_T15_in};

  // Pads and field bits the design deliberately does not look at.
  assign unused_pins = ^{pad_S0_T0_in,  pad_S0_T1_in,  pad_S0_T2_in,  pad_S0_T3_in,
                         pad_S0_T4_in,  pad_S0_T5_in,  pad_S0_T6_in,  pad_S0_T7_in,
                         pad_S0_T8_in,  pad_S0_T9_in,  pad_S0_T10_in, pad_S0_T11_in,
                         pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in,
                         pad_S1_T0_in,  pad_S1_T1_in,  pad_S1_T2_in,  pad_S1_T3_in,
                         pad_S1_T4_in,  pad_S1_T5_in,  pad_S1_T6_in,  pad_S1_T7_in,
                         pad_S1_T8_in,  pad_S1_T9_in,  pad_S1_T10_in, pad_S1_T11_in,
                         pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in,
                         config_addr_in[7:2], config_data_in[31:16],
                         tdi, tms, tck, trst_n};

  // Only the low 256 bytes of address space decode; [1:0] picks the register.
  assign cfg_hit = (config_addr_in[31:8] == 24'd0);

  // Configuration registers: written unconditionally each edge when decoded.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      op_reg    <= OP_DOUBLE;
      const_reg <= 16'd0;
    end else if (cfg_hit) begin
      case (config_addr_in[1:0])
        2'd0:    op_reg    <= config_data_in[3:0];
        2'd1:    const_reg <= config_data_in[15:0];
        default: ;
      endcase
    end
  end

  // Input stage captures both operand words every edge.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      ra <= 16'd0;
      rb <= 16'd0;
    end else begin
      ra <= a;
      rb <= b;
    end
  end

  // Operation select; additions wrap naturally at 16 bits.
  always_comb begin
    result = 16'd0;
    case (op_reg)
      OP_DOUBLE: result = {ra[14:0], 1'b0};
      OP_PASS:   result = ra;
      OP_ADDC:   result = ra + const_reg;
      OP_ADDB:   result = ra + rb;
      OP_AND:    result = ra & rb;
      default:   result = 16'd0;
    endcase
  end

  // Result stage; outputs come only from this register.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      rr <= 16'd0;
    end else begin
      rr <= result;
    end
  end

  assign pad_S0_T0_out  = rr[15];
  assign pad_S0_T1_out  = rr[14];
  assign pad_S0_T2_out  = rr[13];
  assign pad_S0_T3_out  = rr[12];
  assign pad_S0_T4_out  = rr[11];
  assign pad_S0_T5_out  = rr[10];
  assign pad_S0_T6_out  = rr[9];
  assign pad_S0_T7_out  = rr[8];
  assign pad_S0_T8_out  = rr[7];
  assign pad_S0_T9_out  = rr[6];
  assign pad_S0_T10_out = rr[5];
  assign pad_S0_T11_out = rr[4];
  assign pad_S0_T12_out = rr[3];
  assign pad_S0_T13_out = rr[2];
  assign pad_S0_T14_out = rr[1];
  assign pad_S0_T15_out = rr[0];

  assign tdo = 1'b0;

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - directed-vector bench for the two-stage word datapath
`timescale 1ns/1ps
module tb_top;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic [31:0] config_addr_in = 32'd0;
  logic [31:0] config_data_in = 32'd0;
  logic [15:0] s0_in = 16'd0;
  logic [15:0] s1_in = 16'd0;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic        tdi = 1'b0;
  logic        tms = 1'b0;
  logic        tck = 1'b0;
  logic        trst_n = 1'b1;
  wire  [15:0] r;
  wire         tdo;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_in = ~clk_in;

  top dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .config_addr_in(config_addr_in), .config_data_in(config_data_in),
    .pad_S0_T0_in(s0_in[15]),  .pad_S0_T1_in(s0_in[14]),  .pad_S0_T2_in(s0_in[13]),  .pad_S0_T3_in(s0_in[12]),
    .pad_S0_T4_in(s0_in[11]),  .pad_S0_T5_in(s0_in[10]),  .pad_S0_T6_in(s0_in[9]),   .pad_S0_T7_in(s0_in[8]),
    .pad_S0_T8_in(s0_in[7]),   .pad_S0_T9_in(s0_in[6]),   .pad_S0_T10_in(s0_in[5]),  .pad_S0_T11_in(s0_in[4]),
    .pad_S0_T12_in(s0_in[3]),  .pad_S0_T13_in(s0_in[2]),  .pad_S0_T14_in(s0_in[1]),  .pad_S0_T15_in(s0_in[0]),
    .pad_S1_T0_in(s1_in[15]),  .pad_S1_T1_in(s1_in[14]),  .pad_S1_T2_in(s1_in[13]),  .pad_S1_T3_in(s1_in[12]),
    .pad_S1_T4_in(s1_in[11]),  .pad_S1_T5_in(s1_in[10]),  .pad_S1_T6_in(s1_in[9]),   .pad_S1_T7_in(s1_in[8]),
    .pad_S1_T8_in(s1_in[7]),   .pad_S1_T9_in(s1_in[6]),   .pad_S1_T10_in(s1_in[5]),  .pad_S1_T11_in(s1_in[4]),
    .pad_S1_T12_in(s1_in[3]),  .pad_S1_T13_in(s1_in[2]),  .pad_S1_T14_in(s1_in[1]),  .pad_S1_T15_in(s1_in[0]),
    .pad_S2_T0_in(a[15]),  .pad_S2_T1_in(a[14]),  .pad_S2_T2_in(a[13]),  .pad_S2_T3_in(a[12]),
    .pad_S2_T4_in(a[11]),  .pad_S2_T5_in(a[10]),  .pad_S2_T6_in(a[9]),   .pad_S2_T7_in(a[8]),
    .pad_S2_T8_in(a[7]),   .pad_S2_T9_in(a[6]),   .pad_S2_T10_in(a[5]),  .pad_S2_T11_in(a[4]),
    .pad_S2_T12_in(a[3]),  .pad_S2_T13_in(a[2]),  .pad_S2_T14_in(a[1]),  .pad_S2_T15_in(a[0]),
    .pad_S3_T0_in(b[15]),  .pad_S3_T1_in(b[14]),  .pad_S3_T2_in(b[13]),  .pad_S3_T3_in(b[12]),
    .pad_S3_T4_in(b[11]),  .pad_S3_T5_in(b[10]),  .pad_S3_T6_in(b[9]),   .pad_S3_T7_in(b[8]),
    .pad_S3_T8_in(b[7]),   .pad_S3_T9_in(b[6]),   .pad_S3_T10_in(b[5]),  .pad_S3_T11_in(b[4]),
    .pad_S3_T12_in(b[3]),  .pad_S3_T13_in(b[2]),  .pad_S3_T14_in(b[1]),  .pad_S3_T15_in(b[0]),
    .pad_S0_T0_out(r[15]), .pad_S0_T1_out(r[14]), .pad_S0_T2_out(r[13]), .pad_S0_T3_out(r[12]),
    .pad_S0_T4_out(r[11]), .pad_S0_T5_out(r[10]), .pad_S0_T6_out(r[9]),  .pad_S0_T7_out(r[8]),
    .pad_S0_T8_out(r[7]),  .pad_S0_T9_out(r[6]),  .pad_S0_T10_out(r[5]), .pad_S0_T11_out(r[4]),
    .pad_S0_T12_out(r[3]), .pad_S0_T13_out(r[2]), .pad_S0_T14_out(r[1]), .pad_S0_T15_out(r[0]),
    .tdi(tdi), .tms(tms), .tck(tck), .trst_n(trst_n), .tdo(tdo)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One config write on the next edge, then park on a reserved address.
  task automatic write_cfg(input logic [31:0] addr, input logic [31:0] data);
    config_addr_in = addr;
    config_data_in = data;
    tick();
    config_addr_in = 32'd2;
    config_data_in = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset();
    a = 16'h00FF;
    reset_in = 1'b0;
    #3;
    vectors++;
    if (r !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_r: got %h want %h", r, 16'h0000);
    end
    vectors++;
    if (tdo !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tdo: got %b want 0", tdo);
    end
    tick();
    tick();
    vectors++;
    if (r !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_hold_r: got %h want %h", r, 16'h0000);
    end
    reset_in = 1'b1;
  endtask

  task automatic test_steady();
    config_addr_in = 32'd0;
    config_data_in = 32'd0;
    s0_in = 16'hFFFF;
    s1_in = 16'hA5A5;
    a = 16'h0002;
    tick();
    tick();
    tick();
    for (int c = 3; c <= 100; c++) begin
      vectors++;
      if (r !== 16'h0004) begin
        miscompares++;
        $display("FAIL steady_x2 cycle %0d: got %h want %h", c, r, 16'h0004);
      end
      vectors++;
      if (tdo !== 1'b0) begin
        miscompares++;
        $display("FAIL steady_tdo cycle %0d: got %b want 0", c, tdo);
      end
      tick();
    end
    vectors++;
    if (dut.pad_S0_T13_out !== 1'b1) begin
      miscompares++;
      $display("FAIL steady_pad_T13: got %b want 1", dut.pad_S0_T13_out);
    end
  endtask

  task automatic test_async_reset();
    #3;
    reset_in = 1'b0;
    #1;
    vectors++;
    if (r !== 16'h0000) begin
      miscompares++;
      $display("FAIL async_reset_r: got %h want %h", r, 16'h0000);
    end
    vectors++;
    if (tdo !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_tdo: got %b want 0", tdo);
    end
    // Writes during reset must be ignored: OP must come back as x2.
    config_addr_in = 32'd0;
    config_data_in = 32'd3;
    b = 16'h0010;
    tick();
    config_addr_in = 32'd2;
    #2;
    reset_in = 1'b1;
    a = 16'h0002;
    tick();
    vectors++;
    if (r !== 16'h0000) begin
      miscompares++;
      $display("FAIL post_reset_edge1: got %h want %h", r, 16'h0000);
    end
    tick();
    vectors++;
    if (r !== 16'h0004) begin
      miscompares++;
      $display("FAIL post_reset_edge2: got %h want %h", r, 16'h0004);
    end
  endtask

  task automatic test_overflow();
    a = 16'h8001;
    tick();
    tick();
    vectors++;
    if (r !== 16'h0002) begin
      miscompares++;
      $display("FAIL x2_overflow: got %h want %h", r, 16'h0002);
    end
  endtask

  task automatic test_add_const();
    write_cfg(32'd1, 32'hABCD_0005);
    write_cfg(32'd0, 32'd2);
    a = 16'hFFFE;
    tick();
    tick();
    vectors++;
    if (r !== 16'h0003) begin
      miscompares++;
      $display("FAIL add_const_wrap: got %h want %h", r, 16'h0003);
    end
    // Reserved address 3 write must not disturb OP or CONST.
    write_cfg(32'd3, 32'h0000_0004);
    tick();
    vectors++;
    if (r !== 16'h0003) begin
      miscompares++;
      $display("FAIL reserved_write: got %h want %h", r, 16'h0003);
    end
  endtask

  task automatic test_add_b_and_decode();
    write_cfg(32'd0, 32'd3);
    a = 16'h1234;
    b = 16'h0001;
    tick();
    tick();
    vectors++;
    if (r !== 16'h1235) begin
      miscompares++;
      $display("FAIL add_b: got %h want %h", r, 16'h1235);
    end
    config_addr_in = 32'h0000_0100;
    config_data_in = 32'd1;
    a = 16'h1000;
    b = 16'h0FFF;
    tick();
    tick();
    tick();
    vectors++;
    if (r !== 16'h1FFF) begin
      miscompares++;
      $display("FAIL high_addr_ignored: got %h want %h", r, 16'h1FFF);
    end
    config_addr_in = 32'd2;
  endtask

  task automatic test_other_ops();
    logic [3:0]  ops  [4] = '{4'd4, 4'd1, 4'd7, 4'd15};
    logic [15:0] want [4] = '{16'h3030, 16'hF0F0, 16'h0000, 16'h0000};
    a = 16'hF0F0;
    b = 16'h3C3C;
    for (int i = 0; i < 4; i++) begin
      write_cfg(32'd0, {28'd0, ops[i]});
      tick();
      vectors++;
      if (r !== want[i]) begin
        miscompares++;
        $display("FAIL op_%0d: got %h want %h", ops[i], r, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    write_cfg(32'd0, 32'd0);
    a = 16'h0001;
    tick();
    tick();
    vectors++;
    if (r !== 16'h0002) begin
      miscompares++;
      $display("FAIL b2b_before: got %h want %h", r, 16'h0002);
    end
    a = 16'h0003;
    tick();
    vectors++;
    if (r !== 16'h0002) begin
      miscompares++;
      $display("FAIL b2b_edge_k: got %h want %h", r, 16'h0002);
    end
    tick();
    vectors++;
    if (r !== 16'h0006) begin
      miscompares++;
      $display("FAIL b2b_edge_k1: got %h want %h", r, 16'h0006);
    end
  endtask

  task automatic test_config_latency();
    write_cfg(32'd0, 32'd1);
    a = 16'h0005;
    tick();
    tick();
    vectors++;
    if (r !== 16'h0005) begin
      miscompares++;
      $display("FAIL cfg_lat_pass: got %h want %h", r, 16'h0005);
    end
    write_cfg(32'd0, 32'd0);
    vectors++;
    if (r !== 16'h0005) begin
      miscompares++;
      $display("FAIL cfg_lat_edge_k: got %h want %h", r, 16'h0005);
    end
    tick();
    vectors++;
    if (r !== 16'h000A) begin
      miscompares++;
      $display("FAIL cfg_lat_edge_k1: got %h want %h", r, 16'h000A);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_steady();
    test_async_reset();
    test_overflow();
    test_add_const();
    test_add_b_and_decode();
    test_other_ops();
    test_back_to_back();
    test_config_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
